// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with synchronous clear and load,
// wrap-or-saturate range end, cascade terminal count and wrap/overflow status.
module updown_mod_counter #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
    parameter bit               SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             up_down,
    output logic [WIDTH-1:0] counter_out,
    output logic             tc,
    output logic             wrap,
    output logic             overflow
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;

    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] load_clamped;
    logic             count_en;

    assign at_max       = (count_q == MAX_COUNT);
    assign at_zero      = (count_q == '0);
    // Loaded values beyond the range are clamped so the count never leaves 0..MAX_COUNT.
    assign load_clamped = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;
    assign count_en     = enable & ~clear & ~load;

    // Next-state: clear > load > enable > hold.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        if (clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            count_d = load_clamped;
        end else if (enable) begin
            if (up_down) begin
                if (at_max) begin
                    count_d = SATURATE ? MAX_COUNT : '0;
                    wrap_d  = 1'b1;
                    ovf_d   = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (at_zero) begin
                    count_d = SATURATE ? '0 : MAX_COUNT;
                    wrap_d  = 1'b1;
                    ovf_d   = 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    // Terminal count is combinational so a following stage can count on the same edge.
    assign tc = count_en & ((up_down & at_max) | (~up_down & at_zero));

    assign counter_out = count_q;
    assign wrap        = wrap_q;
    assign overflow    = ovf_q;

endmodule
